// File: rtl/kc87_tap_pkg.sv
// kc87_tap_pkg: shared types and constants for the KC87 tape-save upload path.
//   tap_state_e  - upload block FSM states
//   rd_src_e     - source selected for an ioctl read (header ROM, buffer, zero fill)
//   HDR_LEN      - KC TAP file header length in bytes
//   HDR_BYTES    - header contents: 0xC3 followed by "KC-TAPE by AF. "
//   KC_BLK_LEN   - length of one KC tape block (block byte + 128 data bytes)
package kc87_tap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecord,
        StReady,
        StUpload
    } tap_state_e;

    typedef enum logic [1:0] {
        SrcHdr,
        SrcRam,
        SrcZero
    } rd_src_e;

    localparam int unsigned HDR_LEN    = 16;
    localparam int unsigned HDR_AW     = 4;
    localparam int unsigned KC_BLK_LEN = 129;

    localparam logic [7:0] HDR_BYTES [HDR_LEN] = '{
        8'hC3,
        8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45, 8'h20,  // "KC-TAPE "
        8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20          // "by AF. "
    };

endpackage

// File: rtl/kc87_tap_buf.sv
// kc87_tap_buf: simple dual-port byte RAM (2**ADDR_W x 8) for the recorded tape stream.
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - registered read data, valid one cycle after raddr
// No reset on the array or read register so the memory maps onto block RAM.
module kc87_tap_buf #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/kc87_tap_upload.sv
// kc87_tap_upload: captures the byte stream decoded while a program is saved to tape and
// serves it to hps_io as an ioctl upload with the 16-byte KC TAP header prepended.
//   clk, reset_n          - system clock, asynchronous active-low reset
//   rec_start, rec_stop   - one-cycle pulses that begin / end a recording
//   byte_valid, byte_data - decoded tape byte stream
//   ioctl_upload          - hps_io upload in progress
//   ioctl_rd, ioctl_addr  - hps_io read strobe and file offset
//   ioctl_din, ioctl_wait - read data (valid two cycles after ioctl_rd) and stall
//   upload_req            - one-cycle pulse when a recording is ready for upload
//   file_len              - header length plus stored byte count
//   overflow              - sticky: bytes were dropped because the buffer was full
//   busy                  - recording or uploading
module kc87_tap_upload
    import kc87_tap_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              upload_req,
    output logic [ADDR_W+4:0] file_len,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LEN_W = ADDR_W + 5;

    tap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_d;
    logic              upload_q;
    logic              pending_q;
    rd_src_e           src_q, src_d;
    logic [7:0]        hdr_q;

    logic              rec_restart;
    logic              in_rec;
    logic              full;
    logic              wr_en;
    logic              drop;
    logic              up_rise, up_fall;
    logic              rd_take;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        ram_rdata;

    // Record path. A restart takes precedence over a byte arriving in the same cycle.
    always_comb begin
        rec_restart = rec_start && (state_q != StUpload);
        in_rec      = (state_q == StRecord) && !rec_restart;
        full        = count_q[ADDR_W];
        wr_en       = in_rec && byte_valid && !full;
        drop        = in_rec && byte_valid && full;
        count_d     = rec_restart ? '0 : count_q + CNT_W'(wr_en);
        overflow_d  = rec_restart ? 1'b0 : (overflow | drop);
        up_rise     = ioctl_upload && !upload_q;
        up_fall     = !ioctl_upload && upload_q;
    end

    // Stop is judged on count_d so a byte arriving with rec_stop is counted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rec_start) state_d = StRecord;
            end
            StRecord: begin
                if (rec_start) begin
                    state_d = StRecord;
                end else if (rec_stop) begin
                    state_d = (count_d != '0) ? StReady : StIdle;
                end
            end
            StReady: begin
                if (rec_start) begin
                    state_d = StRecord;
                end else if (up_rise) begin
                    state_d = StUpload;
                end
            end
            StUpload: begin
                if (up_fall) state_d = StReady;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read path: source decided in the strobe cycle, data registered one cycle later.
    always_comb begin
        rd_take    = (state_q == StUpload) && ioctl_rd && !pending_q;
        ioctl_wait = ((state_q == StUpload) && ioctl_rd) || pending_q;
        raddr      = ADDR_W'(ioctl_addr - 25'(HDR_LEN));
        if (ioctl_addr < 25'(HDR_LEN)) begin
            src_d = SrcHdr;
        end else if (ioctl_addr < 25'(file_len)) begin
            src_d = SrcRam;
        end else begin
            src_d = SrcZero;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            overflow   <= 1'b0;
            file_len   <= LEN_W'(HDR_LEN);
            upload_req <= 1'b0;
            busy       <= 1'b0;
            upload_q   <= 1'b0;
            pending_q  <= 1'b0;
            src_q      <= SrcZero;
            hdr_q      <= 8'h00;
            ioctl_din  <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow   <= overflow_d;
            file_len   <= LEN_W'(HDR_LEN) + LEN_W'(count_d);
            upload_req <= (state_q == StRecord) && (state_d == StReady);
            busy       <= (state_d == StRecord) || (state_d == StUpload);
            upload_q   <= ioctl_upload;
            if (rd_take) begin
                pending_q <= 1'b1;
                src_q     <= src_d;
                hdr_q     <= HDR_BYTES[ioctl_addr[HDR_AW-1:0]];
            end else if (pending_q) begin
                pending_q <= 1'b0;
                unique case (src_q)
                    SrcHdr:  ioctl_din <= hdr_q;
                    SrcRam:  ioctl_din <= ram_rdata;
                    default: ioctl_din <= 8'h00;
                endcase
            end
        end
    end

    kc87_tap_buf #(
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk  (clk),
        .we   (wr_en),
        .waddr(count_q[ADDR_W-1:0]),
        .wdata(byte_data),
        .raddr(raddr),
        .rdata(ram_rdata)
    );

endmodule

// File: doc/kc87_tap_upload.md
Name: kc87_tap_upload

Overview:
Tape-save path of the KC87 core, the reverse direction of the TAP download/load path. It captures the byte stream that the emulated cassette interface decodes while a program is being saved into an on-chip buffer. It then serves that buffer to hps_io as an ioctl upload, so the HPS writes a .TAP file to SD. The block prepends the 16-byte KC TAP file header automatically, so the core never stores it.

Parameters:
- ADDR_W, 15, buffer address width; capacity is 2**ADDR_W data bytes (header excluded).
- HDR_LEN, 16, TAP header length in bytes; fixed by the file format and taken from the package.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous active-low reset.
- rec_start  in  1  one-cycle pulse that begins a new recording.
- rec_stop  in  1  one-cycle pulse that ends the recording.
- byte_valid  in  1  a decoded tape byte is present this cycle.
- byte_data  in  8  decoded tape byte.
- ioctl_upload  in  1  hps_io upload in progress.
- ioctl_rd  in  1  hps_io read strobe.
- ioctl_addr  in  25  hps_io read address (file offset).
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  stalls hps_io until ioctl_din is valid.
- upload_req  out  1  one-cycle pulse: a file is ready for upload.
- file_len  out  ADDR_W+5  total file length in bytes = HDR_LEN + stored count.
- overflow  out  1  sticky flag: bytes were dropped because the buffer was full.
- busy  out  1  high in RECORD or UPLOAD.

Behaviour:
- Reset values (async, reset_n low): state IDLE; count=0; ioctl_din=0x00; ioctl_wait=0; upload_req=0; overflow=0; busy=0. Buffer contents are undefined and are not cleared.
- States and transitions:
  - IDLE: rec_start -> RECORD.
  - RECORD: on rec_stop, go to READY if count>0, otherwise to IDLE.
  - READY: ioctl_upload rising -> UPLOAD.
  - UPLOAD: ioctl_upload falling -> READY.
- rec_start from IDLE, RECORD or READY: clears count and overflow, enters RECORD. A rec_start in RECORD restarts the recording. rec_start in UPLOAD is ignored.
- RECORD write: on byte_valid with count < 2**ADDR_W, write byte_data to buffer[count], then count+1.
  - When count = 2**ADDR_W, the byte is dropped and overflow is set. count saturates and never wraps.
- byte_valid and rec_stop in the same cycle: the byte is stored first (count includes it), then the stop transition is evaluated with the updated count.
- byte_valid outside RECORD is ignored.
- upload_req pulses exactly one cycle, on the cycle READY is entered from RECORD.
- file_len is registered and equals HDR_LEN + count at all times.
- Read handshake: ioctl_rd is honoured only in UPLOAD; in all other states ioctl_wait stays 0 and ioctl_din holds its value. For an ioctl_rd in cycle N:
  - ioctl_wait = ioctl_rd OR pending, combinational. It is high in cycles N and N+1 and low in N+2.
  - ioctl_din is registered and valid from N+2 until the next read.
  - A new ioctl_rd while pending is ignored; hps_io does not issue one.
- Read mux, with a = ioctl_addr:
  - a < HDR_LEN: header ROM byte a.
  - HDR_LEN <= a < file_len: buffer[a - HDR_LEN].
  - a >= file_len: 0x00.
- The header ROM holds 0xC3 followed by the ASCII text "KC-TAPE by AF. " (15 characters, total 16 bytes).
- Buffer read path latency is one cycle (synchronous RAM) plus the output register, giving two cycles.
- reset_n asserted mid-RECORD or mid-UPLOAD: immediate return to IDLE, with pending and the outputs cleared as listed above.

Decomposition:
- Package kc87_tap_pkg holds:
  - the state enum (IDLE, RECORD, READY, UPLOAD);
  - HDR_LEN = 16;
  - the 16-byte header constant array;
  - KC_BLK_LEN = 129, used only by the bench.
- One sub-module, kc87_tap_buf: simple dual-port RAM, 2**ADDR_W x 8, with one write port and one registered read port, inferable as block RAM.
- The FSM, count and read mux stay in the top.

Test Plan:
1. Record bytes 0x01, 0x02, 0x03, then rec_stop -> upload_req pulses once; file_len = 19. An upload reading addresses 0..19 returns 0xC3, "KC-TAPE by AF. ", 0x01, 0x02, 0x03, 0x00. Each read shows ioctl_wait high for exactly 2 cycles.
2. ADDR_W=4: record 20 bytes -> count saturates at 16; overflow=1; file_len = 32. Bytes 17-20 are absent. A following rec_start clears overflow.
3. rec_start then immediate rec_stop with no bytes -> returns to IDLE; upload_req never pulses; file_len = 16.
4. byte_valid=1 (0xAA) in the same cycle as rec_stop -> count includes 0xAA; a read at address 16 returns 0xAA.
5. During UPLOAD: pulse rec_start and byte_valid -> both ignored; file_len and buffer unchanged. ioctl_upload falling returns the state to READY.
6. reset_n low for one cycle mid-RECORD (count=5) -> IDLE, count=0, busy=0, ioctl_wait=0, no upload_req. An ioctl_rd issued afterwards gets no wait.
